// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the 16-bit SPI master/slave pair.
package spi_pkg;

    localparam int unsigned FRAME_BITS  = 16;

    // Legal ranges, also used by the slave side
    localparam int unsigned CLK_DIV_MIN = 2;
    localparam int unsigned CLK_DIV_MAX = 255;
    localparam int unsigned GAP_HP_MIN  = 1;
    localparam int unsigned GAP_HP_MAX  = 15;

    localparam int unsigned HP_CNT_W    = $clog2(CLK_DIV_MAX + 1);
    localparam int unsigned GAP_CNT_W   = $clog2(GAP_HP_MAX + 1);
    localparam int unsigned BIT_CNT_W   = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } spi_state_e;

    function automatic bit params_legal(input int unsigned clk_div, input int unsigned gap_hp);
        return (clk_div >= CLK_DIV_MIN) && (clk_div <= CLK_DIV_MAX) &&
               (gap_hp >= GAP_HP_MIN) && (gap_hp <= GAP_HP_MAX);
    endfunction

endpackage

// File: rtl/spi_hp_tick.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and pulses tick on the last count.
module spi_hp_tick
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 6
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [HP_CNT_W-1:0] HP_LAST = HP_CNT_W'(CLK_DIV - 1);

    logic [HP_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clr && (cnt_q == HP_LAST);
        cnt_d = cnt_q + HP_CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_16bit.sv
// Mode-0 SPI initiator, one 16-bit full-duplex frame per accepted start, index 0 first.
// Optional macro SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds MOSI back into rx.
module spi_master_16bit
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 6,
    parameter int unsigned GAP_HP  = 1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic [0:15] tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic        loopback,
`endif
    output logic        busy,
    output logic        done,
    output logic [0:15] rx_data,
    output logic        SPI_SCLK,
    output logic        SPI_MOSI,
    output logic        SPI_CS,
    input  logic        SPI_MISO
);

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_HP - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    spi_state_e                state_q, state_d;
    logic [0:FRAME_BITS-1]     tx_sr_q, tx_sr_d;
    logic [0:FRAME_BITS-1]     rx_sr_q, rx_sr_d;
    logic [0:FRAME_BITS-1]     rx_data_q, rx_data_d;
    logic [0:FRAME_BITS-1]     rx_shift;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                      sclk_q, sclk_d;
    logic                      cs_q, cs_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      hp_clr, hp_tick;
    logic                      rx_bit;

    assign hp_clr = (state_q == StIdle);

    spi_hp_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_hp_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (hp_clr),
        .tick   (hp_tick)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q, lb_d;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            lb_q <= 1'b0;
        end else begin
            lb_q <= lb_d;
        end
    end

    // tx_sr_q[0] is the bit currently on MOSI
    assign rx_bit = lb_q ? tx_sr_q[0] : SPI_MISO;
`else
    assign rx_bit = SPI_MISO;
`endif

    assign rx_shift = {rx_sr_q[1:FRAME_BITS-1], rx_bit};

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_d      = lb_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    tx_sr_d   = tx_data;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = StSetup;
`ifdef SPI_MASTER_LOOPBACK_EN
                    lb_d      = loopback;
`endif
                end
            end
            StSetup: begin
                if (hp_tick) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = rx_shift;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (hp_tick) begin
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        // Last bit stays on MOSI until CS rises
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = StHold;
                        end else begin
                            tx_sr_d = {tx_sr_q[1:FRAME_BITS-1], 1'b0};
                        end
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sr_d = rx_shift;
                    end
                end
            end
            StHold: begin
                if (hp_tick) begin
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                    tx_sr_d   = '0;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (hp_tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q   <= StIdle;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign SPI_SCLK = sclk_q;
    assign SPI_MOSI = tx_sr_q[0];
    assign SPI_CS   = cs_q;

endmodule

// File: tb/tb_spi_master_16bit.sv
// Directed bench for spi_master_16bit: default instance with a sampled slave model,
// plus a CLK_DIV=2 instance for edge timing (and loopback when SPI_MASTER_LOOPBACK_EN is set).
module tb_spi_master_16bit;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Default instance
    logic        rst, start, busy, done, sclk, mosi, cs;
    logic        miso = 1'b0;
    logic [0:15] tx_data, rx_data;

    // CLK_DIV=2 instance, MISO tied low
    logic        rst2, start2, busy2, done2, sclk2, mosi2, cs2;
    logic        miso2 = 1'b0;
    logic [0:15] tx2, rx2;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic loopback  = 1'b0;
    logic loopback2 = 1'b0;
`endif

    spi_master_16bit dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .tx_data  (tx_data),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback (loopback),
`endif
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .SPI_SCLK (sclk),
        .SPI_MOSI (mosi),
        .SPI_CS   (cs),
        .SPI_MISO (miso)
    );

    spi_master_16bit #(
        .CLK_DIV (2),
        .GAP_HP  (1)
    ) dut2 (
        .clk_in   (clk_in),
        .rst      (rst2),
        .start    (start2),
        .tx_data  (tx2),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback (loopback2),
`endif
        .busy     (busy2),
        .done     (done2),
        .rx_data  (rx2),
        .SPI_SCLK (sclk2),
        .SPI_MOSI (mosi2),
        .SPI_CS   (cs2),
        .SPI_MISO (miso2)
    );

    int checks = 0;
    int errors = 0;

    // Monitor + mode-0 slave model for the default instance, sampled on the falling clock edge
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
    int          cs_falls = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, gap_cyc = 0;
    int          busy_fall_cyc = 0, done_cnt = 0, done_cyc = 0, rises = 0, viol = 0;
    int          slv_bit = 0, slv_n = 0;
    logic [0:15] slv_word = 16'h0000;
    logic [0:15] slv_rx = 16'h0000;
    logic [0:15] slv_words [0:15];

    always @(negedge clk_in) begin
        if (cs && sclk) viol++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_cs && !cs) begin
            cs_falls++;
            gap_cyc     = cyc - cs_rise_cyc;
            cs_fall_cyc = cyc;
            slv_bit     = 0;
            slv_rx      = 16'h0000;
            miso        = slv_word[0];
        end
        if (!prev_cs && cs) begin
            cs_rise_cyc = cyc;
            if (slv_n < 16) slv_words[slv_n] = slv_rx;
            slv_n++;
        end
        if (!cs && !prev_sclk && sclk) begin
            rises++;
            slv_rx = {slv_rx[1:15], mosi};
        end
        if (!cs && prev_sclk && !sclk) begin
            slv_bit++;
            if (slv_bit < 16) miso = slv_word[slv_bit];
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_cs   = cs;
        prev_sclk = sclk;
        prev_busy = busy;
    end

    logic prev_cs2 = 1'b1, prev_sclk2 = 1'b0, prev_busy2 = 1'b0, seen2 = 1'b0;
    int   cs2_fall_cyc = 0, cs2_rise_cyc = 0, rise2_cyc = 0, busy2_fall_cyc = 0;

    always @(negedge clk_in) begin
        if (prev_cs2 && !cs2) begin
            cs2_fall_cyc = cyc;
            seen2        = 1'b0;
        end
        if (!prev_sclk2 && sclk2 && !seen2) begin
            rise2_cyc = cyc;
            seen2     = 1'b1;
        end
        if (!prev_cs2 && cs2) cs2_rise_cyc = cyc;
        if (prev_busy2 && !busy2) busy2_fall_cyc = cyc;
        prev_cs2   = cs2;
        prev_sclk2 = sclk2;
        prev_busy2 = busy2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_in);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic wait_idle2(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_in);
            if (!busy2) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   t0, b_done, b_rises, b_slv, b_falls;

        rst = 1'b0; start = 1'b0; tx_data = 16'h0000;
        rst2 = 1'b0; start2 = 1'b0; tx2 = 16'h0000;
        repeat (3) @(negedge clk_in);

        // Reset state
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 16'h0000);
        check("rst_cs2", cs2, 1);
        rst = 1'b1; rst2 = 1'b1;
        repeat (2) @(negedge clk_in);

        // Single frame with default timing
        slv_word = 16'h3C5A; tx_data = 16'hA5C3;
        b_done = done_cnt; b_rises = rises; b_slv = slv_n;
        t0 = cyc; start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        wait_idle(400, ok);
        check("f1_finish", ok, 1);
        check("f1_cs_fall", cs_fall_cyc - t0, 1);
        check("f1_cs_rise", cs_rise_cyc - t0, 199);
        check("f1_cs_low", cs_rise_cyc - cs_fall_cyc, 198);
        check("f1_rises", rises - b_rises, 16);
        check("f1_done_cnt", done_cnt - b_done, 1);
        check("f1_done_at_cs", done_cyc - t0, 199);
        check("f1_busy_fall", busy_fall_cyc - t0, 205);
        check("f1_rx", rx_data, 16'h3C5A);
        check("f1_slave_rx", slv_words[b_slv], 16'hA5C3);

        // Edge timing with CLK_DIV=2
        tx2 = 16'h1234;
        t0 = cyc; start2 = 1'b1;
        @(negedge clk_in); start2 = 1'b0;
        wait_idle2(200, ok);
        check("d2_finish", ok, 1);
        check("d2_cs_fall", cs2_fall_cyc - t0, 1);
        check("d2_first_rise", rise2_cyc - t0, 3);
        check("d2_cs_rise", cs2_rise_cyc - t0, 67);
        check("d2_busy_fall", busy2_fall_cyc - t0, 69);

        // Start pulse in mid-frame is ignored
        slv_word = 16'h0F0F; tx_data = 16'h1234;
        b_done = done_cnt; b_rises = rises; b_slv = slv_n; b_falls = cs_falls;
        t0 = cyc; start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        repeat (49) @(negedge clk_in);
        tx_data = 16'hFFFF; start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        wait_idle(400, ok);
        repeat (20) @(negedge clk_in);
        check("ign_finish", ok, 1);
        check("ign_frames", cs_falls - b_falls, 1);
        check("ign_done_cnt", done_cnt - b_done, 1);
        check("ign_rises", rises - b_rises, 16);
        check("ign_slave_rx", slv_words[b_slv], 16'h1234);
        check("ign_rx", rx_data, 16'h0F0F);
        check("ign_busy", busy, 0);

        // Start held high: back-to-back frames, bit order
        slv_word = 16'hFFFF; tx_data = 16'h0001;
        b_done = done_cnt; b_rises = rises; b_slv = slv_n; b_falls = cs_falls;
        start = 1'b1;
        @(negedge clk_in);
        tx_data = 16'h8000;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_in);
            if (cs_falls - b_falls >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("b2b_second", ok, 1);
        wait_idle(400, ok);
        check("b2b_finish", ok, 1);
        check("b2b_frames", cs_falls - b_falls, 2);
        check("b2b_done_cnt", done_cnt - b_done, 2);
        check("b2b_rises", rises - b_rises, 32);
        check("b2b_gap", gap_cyc, 7);
        check("b2b_word0", slv_words[b_slv], 16'h0001);
        check("b2b_word1", slv_words[b_slv + 1], 16'h8000);
        check("b2b_rx", rx_data, 16'hFFFF);

        // Reset after 7 SCLK rises aborts the frame
        slv_word = 16'hFFFF; tx_data = 16'hFFFF;
        b_done = done_cnt; b_rises = rises;
        start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (rises - b_rises >= 7) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach7", ok, 1);
        check("abort_pre_mosi", mosi, 1);
        rst = 1'b0;
        @(negedge clk_in);
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        check("abort_rx", rx_data, 16'h0000);
        check("abort_done", done, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        check("abort_no_done", done_cnt - b_done, 0);
        check("abort_rises", rises - b_rises, 7);

        // Fresh frame after abort
        slv_word = 16'h2468; tx_data = 16'h1357;
        b_done = done_cnt; b_slv = slv_n;
        start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        wait_idle(400, ok);
        check("post_finish", ok, 1);
        check("post_rx", rx_data, 16'h2468);
        check("post_slave_rx", slv_words[b_slv], 16'h1357);
        check("post_done_cnt", done_cnt - b_done, 1);

`ifdef SPI_MASTER_LOOPBACK_EN
        loopback2 = 1'b1; tx2 = 16'hDEAD;
        start2 = 1'b1;
        @(negedge clk_in); start2 = 1'b0; loopback2 = 1'b0;
        wait_idle2(200, ok);
        check("lb_finish", ok, 1);
        check("lb_rx", rx2, 16'hDEAD);
`endif

        check("sclk_high_cs_high", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
